elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_scheduler.sv | 163 ++++++++++++++++
 tb/tb_elevator_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// SCAN-order elevator controller: latches floor requests, keeps serving in the
// current travel direction while requests lie ahead, and reverses only at a floor.
module elevator_scheduler #(
    parameter int NFLOOR      = 4,
    parameter int MOVE_CYCLES = 100000000,
    parameter int DOOR_CYCLES = 150000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NFLOOR-1:0] req_press,
    output logic [NFLOOR-1:0] pending,
    output logic [2:0]        cur_floor,
    output logic              dir_up,
    output logic              moving,
    output logic              door_open,
    output logic [1:0]        state
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MOVE_UP   = 2'd1;
    localparam logic [1:0] S_MOVE_DOWN = 2'd2;
    localparam logic [1:0] S_DOOR_OPEN = 2'd3;

    localparam logic [31:0] MOVE_LAST = 32'(MOVE_CYCLES - 1);
    localparam logic [31:0] DOOR_LAST = 32'(DOOR_CYCLES - 1);

    logic [1:0]        r_state;
    logic [NFLOOR-1:0] r_pending;
    logic [2:0]        r_cur_floor;
    logic              r_dir_up;
    logic              r_moving;
    logic              r_door_open;
    logic [31:0]       r_timer;

    logic [1:0]        w_state_next;
    logic [2:0]        w_floor_next;
    logic              w_dir_next;
    logic [31:0]       w_timer_next;
    logic [NFLOOR-1:0] w_pending_next;

    logic [2:0]        w_eval_floor;
    logic [NFLOOR-1:0] w_above;
    logic [NFLOOR-1:0] w_below;
    logic [NFLOOR-1:0] w_eval_hot;
    logic [NFLOOR-1:0] w_cur_hot;
    logic [NFLOOR-1:0] w_next_hot;
    logic [NFLOOR-1:0] w_block;
    logic [NFLOOR-1:0] w_clear;
    logic              w_ahead;
    logic              w_behind;
    logic              w_here_hit;
    logic              w_press_here;
    logic              w_go_dir;
    logic [1:0]        w_go_state;
    logic              w_move_done;
    logic              w_door_done;

    // During travel the decision is made for the floor being arrived at.
    always_comb begin
        w_eval_floor = r_cur_floor;
        if (r_state == S_MOVE_UP)
            w_eval_floor = r_cur_floor + 3'd1;
        else if (r_state == S_MOVE_DOWN)
            w_eval_floor = r_cur_floor - 3'd1;
    end

    generate
        for (genvar gi = 0; gi < NFLOOR; gi++) begin : g_floor
            assign w_above[gi]    = r_pending[gi] && (3'(gi) > w_eval_floor);
            assign w_below[gi]    = r_pending[gi] && (3'(gi) < w_eval_floor);
            assign w_eval_hot[gi] = (3'(gi) == w_eval_floor);
            assign w_cur_hot[gi]  = (3'(gi) == r_cur_floor);
            assign w_next_hot[gi] = (3'(gi) == w_floor_next);
        end
    endgenerate

    assign w_ahead      = r_dir_up ? (|w_above) : (|w_below);
    assign w_behind     = r_dir_up ? (|w_below) : (|w_above);
    assign w_here_hit   = |(r_pending & w_eval_hot);
    assign w_press_here = |(req_press & w_cur_hot);
    assign w_go_dir     = w_ahead ? r_dir_up : ~r_dir_up;
    assign w_go_state   = w_go_dir ? S_MOVE_UP : S_MOVE_DOWN;
    assign w_move_done  = ((r_state == S_MOVE_UP) || (r_state == S_MOVE_DOWN)) && (r_timer == MOVE_LAST);
    assign w_door_done  = (r_state == S_DOOR_OPEN) && (r_timer == DOOR_LAST);

    always_comb begin
        w_state_next = r_state;
        w_floor_next = r_cur_floor;
        w_dir_next   = r_dir_up;
        w_timer_next = r_timer + 32'd1;
        case (r_state)
            S_IDLE: begin
                w_timer_next = 32'd0;
                if (w_press_here || w_here_hit) begin
                    w_state_next = S_DOOR_OPEN;
                end else if (w_ahead || w_behind) begin
                    w_state_next = w_go_state;
                    w_dir_next   = w_go_dir;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (w_move_done) begin
                    w_timer_next = 32'd0;
                    w_floor_next = w_eval_floor;
                    if (w_here_hit) begin
                        w_state_next = S_DOOR_OPEN;
                    end else if (w_ahead || w_behind) begin
                        w_state_next = w_go_state;
                        w_dir_next   = w_go_dir;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                if (w_press_here) begin
                    w_timer_next = 32'd0;
                end else if (w_door_done) begin
                    w_timer_next = 32'd0;
                    if (w_ahead || w_behind) begin
                        w_state_next = w_go_state;
                        w_dir_next   = w_go_dir;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
        endcase
    end

    // A press for the floor the car is parked at opens the door instead of queueing.
    assign w_block        = ((r_state == S_IDLE) || (r_state == S_DOOR_OPEN)) ? w_cur_hot : '0;
    assign w_clear        = (w_state_next == S_DOOR_OPEN) ? w_next_hot : '0;
    assign w_pending_next = (r_pending | (req_press & ~w_block)) & ~w_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_cur_floor <= 3'd0;
            r_dir_up    <= 1'b1;
            r_moving    <= 1'b0;
            r_door_open <= 1'b0;
            r_timer     <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pending_next;
            r_cur_floor <= w_floor_next;
            r_dir_up    <= w_dir_next;
            r_moving    <= (w_state_next == S_MOVE_UP) || (w_state_next == S_MOVE_DOWN);
            r_door_open <= (w_state_next == S_DOOR_OPEN);
            r_timer     <= w_timer_next;
        end
    end

    assign state     = r_state;
    assign pending   = r_pending;
    assign cur_floor = r_cur_floor;
    assign dir_up    = r_dir_up;
    assign moving    = r_moving;
    assign door_open = r_door_open;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with short travel/door times
// (MOVE_CYCLES=4, DOOR_CYCLES=3, four floors).
module tb_elevator_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_press;
    logic [3:0] pending;
    logic [2:0] cur_floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [1:0] state;

    int n_cmp;
    int n_err;

    elevator_scheduler #(
        .NFLOOR(4),
        .MOVE_CYCLES(4),
        .DOOR_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_press(req_press),
        .pending(pending),
        .cur_floor(cur_floor),
        .dir_up(dir_up),
        .moving(moving),
        .door_open(door_open),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus changes and all sampling happen on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask);
        req_press = mask;
        @(negedge clk);
        req_press = 4'b0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_press = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        n_cmp++; if (cur_floor !== 3'd0) begin n_err++; $display("FAIL reset_floor got=%0d exp=0", cur_floor); end
        n_cmp++; if (dir_up !== 1'b1) begin n_err++; $display("FAIL reset_dir got=%b exp=1", dir_up); end
        n_cmp++; if ({moving, door_open} !== 2'b00) begin n_err++; $display("FAIL reset_flags got=%b exp=00", {moving, door_open}); end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_single_trip();
        do_reset();
        press(4'b1000);
        n_cmp++; if (pending !== 4'b1000) begin n_err++; $display("FAIL trip_latch got=%b exp=1000", pending); end
        tick(1);
        n_cmp++; if (state !== 2'd1 || moving !== 1'b1 || dir_up !== 1'b1) begin n_err++; $display("FAIL trip_start state=%0d mv=%b dir=%b exp=1/1/1", state, moving, dir_up); end
        tick(4);
        n_cmp++; if (cur_floor !== 3'd1 || state !== 2'd1) begin n_err++; $display("FAIL trip_f1 floor=%0d state=%0d exp=1/1", cur_floor, state); end
        tick(4);
        n_cmp++; if (cur_floor !== 3'd2 || state !== 2'd1) begin n_err++; $display("FAIL trip_f2 floor=%0d state=%0d exp=2/1", cur_floor, state); end
        tick(4);
        n_cmp++; if (cur_floor !== 3'd3 || state !== 2'd3 || door_open !== 1'b1 || moving !== 1'b0 || pending !== 4'b0000)
            begin n_err++; $display("FAIL trip_arrive floor=%0d state=%0d door=%b mv=%b pend=%b exp=3/3/1/0/0000", cur_floor, state, door_open, moving, pending); end
        tick(2);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL trip_door_hold got=%0d exp=3", state); end
        tick(1);
        n_cmp++; if (state !== 2'd0 || door_open !== 1'b0 || cur_floor !== 3'd3) begin n_err++; $display("FAIL trip_idle state=%0d door=%b floor=%0d exp=0/0/3", state, door_open, cur_floor); end
        $display("test_single_trip done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_press_here();
        do_reset();
        press(4'b0001);
        n_cmp++; if (state !== 2'd3 || door_open !== 1'b1 || pending !== 4'b0000) begin n_err++; $display("FAIL here_open state=%0d door=%b pend=%b exp=3/1/0000", state, door_open, pending); end
        tick(1);
        press(4'b0001);
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL here_nolatch got=%b exp=0000", pending); end
        tick(2);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL here_restart got=%0d exp=3", state); end
        tick(1);
        n_cmp++; if (state !== 2'd0 || door_open !== 1'b0) begin n_err++; $display("FAIL here_close state=%0d door=%b exp=0/0", state, door_open); end
        $display("test_press_here done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_scan_order();
        do_reset();
        press(4'b1000);
        tick(2);
        press(4'b0001);
        press(4'b0100);
        n_cmp++; if (pending !== 4'b1101 || cur_floor !== 3'd0 || state !== 2'd1) begin n_err++; $display("FAIL scan_latch pend=%b floor=%0d state=%0d exp=1101/0/1", pending, cur_floor, state); end
        tick(5);
        n_cmp++; if (cur_floor !== 3'd2 || state !== 2'd3 || pending !== 4'b1001) begin n_err++; $display("FAIL scan_stop2 floor=%0d state=%0d pend=%b exp=2/3/1001", cur_floor, state, pending); end
        tick(3);
        n_cmp++; if (state !== 2'd1 || dir_up !== 1'b1) begin n_err++; $display("FAIL scan_leave2 state=%0d dir=%b exp=1/1", state, dir_up); end
        tick(4);
        n_cmp++; if (cur_floor !== 3'd3 || state !== 2'd3 || pending !== 4'b0001) begin n_err++; $display("FAIL scan_stop3 floor=%0d state=%0d pend=%b exp=3/3/0001", cur_floor, state, pending); end
        tick(3);
        n_cmp++; if (state !== 2'd2 || dir_up !== 1'b0 || moving !== 1'b1) begin n_err++; $display("FAIL scan_reverse state=%0d dir=%b mv=%b exp=2/0/1", state, dir_up, moving); end
        tick(8);
        n_cmp++; if (cur_floor !== 3'd1 || state !== 2'd2) begin n_err++; $display("FAIL scan_pass1 floor=%0d state=%0d exp=1/2", cur_floor, state); end
        tick(4);
        n_cmp++; if (cur_floor !== 3'd0 || state !== 2'd3 || pending !== 4'b0000) begin n_err++; $display("FAIL scan_stop0 floor=%0d state=%0d pend=%b exp=0/3/0000", cur_floor, state, pending); end
        tick(3);
        n_cmp++; if (state !== 2'd0 || dir_up !== 1'b0) begin n_err++; $display("FAIL scan_idle state=%0d dir=%b exp=0/0", state, dir_up); end
        $display("test_scan_order done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_multi_press();
        do_reset();
        press(4'b0110);
        n_cmp++; if (pending !== 4'b0110) begin n_err++; $display("FAIL multi_latch got=%b exp=0110", pending); end
        press(4'b0110);
        n_cmp++; if (pending !== 4'b0110 || state !== 2'd1) begin n_err++; $display("FAIL multi_repeat pend=%b state=%0d exp=0110/1", pending, state); end
        tick(4);
        n_cmp++; if (cur_floor !== 3'd1 || state !== 2'd3 || pending !== 4'b0100) begin n_err++; $display("FAIL multi_stop1 floor=%0d state=%0d pend=%b exp=1/3/0100", cur_floor, state, pending); end
        tick(3);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL multi_leave1 got=%0d exp=1", state); end
        tick(4);
        n_cmp++; if (cur_floor !== 3'd2 || state !== 2'd3 || pending !== 4'b0000) begin n_err++; $display("FAIL multi_stop2 floor=%0d state=%0d pend=%b exp=2/3/0000", cur_floor, state, pending); end
        tick(3);
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL multi_idle got=%0d exp=0", state); end
        $display("test_multi_press done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_reset_midway();
        do_reset();
        press(4'b0100);
        tick(9);
        press(4'b0001);
        n_cmp++; if (cur_floor !== 3'd2 || state !== 2'd3 || pending !== 4'b0001) begin n_err++; $display("FAIL mid_setup floor=%0d state=%0d pend=%b exp=2/3/0001", cur_floor, state, pending); end
        #2;
        rst_n = 1'b0;
        req_press = 4'b1000;
        #1;
        n_cmp++; if ({state, pending, cur_floor, dir_up, moving, door_open} !== {2'd0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0})
            begin n_err++; $display("FAIL mid_async state=%0d pend=%b floor=%0d dir=%b mv=%b door=%b exp=0/0000/0/1/0/0", state, pending, cur_floor, dir_up, moving, door_open); end
        tick(2);
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL mid_ignore got=%b exp=0000", pending); end
        req_press = 4'b0000;
        rst_n = 1'b1;
        tick(2);
        n_cmp++; if (state !== 2'd0 || pending !== 4'b0000 || cur_floor !== 3'd0) begin n_err++; $display("FAIL mid_release state=%0d pend=%b floor=%0d exp=0/0000/0", state, pending, cur_floor); end
        $display("test_reset_midway done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_press = 4'b0000;
        @(negedge clk);
        test_reset();
        test_single_trip();
        test_press_here();
        test_scan_order();
        test_multi_press();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
